// File: rtl/camera_emu_pkg.sv
// Shared constants for the synthetic camera source: FSM encoding, chroma level
// and LFSR parameters used by the optional CAMERA_EMU_LFSR_NOISE_EN build.
package camera_emu_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VSYNC  = 3'd1;
  localparam logic [2:0] ST_VBACK  = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_VFRONT = 3'd4;

  localparam logic [7:0] CHROMA_MID = 8'd128;

  // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/camera_emu_lfsr.sv
// 16-bit Fibonacci LFSR giving background luma noise; reseed wins over step.
module camera_emu_lfsr
  import camera_emu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        reseed,
  output logic [15:0] lfsr_out
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed) begin
      lfsr_d = LFSR_SEED;
    end else if (step) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/camera_frame_emulator.sv
// Synthetic YUYV camera with href/vsync framing drawing a dark vertical stripe.
// Define CAMERA_EMU_LFSR_NOISE_EN to add LFSR noise to the background luma.
module camera_frame_emulator
  import camera_emu_pkg::*;
#(
  parameter int H_ACTIVE   = 320,
  parameter int H_BLANK    = 144,
  parameter int V_SYNC     = 3,
  parameter int V_BACK     = 17,
  parameter int V_ACTIVE   = 240,
  parameter int V_FRONT    = 10,
  parameter int LINE_WIDTH = 16,
  parameter int BG_Y       = 235,
  parameter int LINE_Y     = 16
) (
  input  logic       pixel_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [9:0] line_pos,
  output logic [7:0] camera_data,
  output logic       href,
  output logic       vsync,
  output logic       frame_done
);

  localparam logic [15:0] ACTIVE_BYTES = 16'(2 * H_ACTIVE);
  localparam logic [15:0] LAST_BYTE    = 16'(2 * H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] LAST_VSYNC   = 16'(V_SYNC - 1);
  localparam logic [15:0] LAST_VBACK   = 16'(V_BACK - 1);
  localparam logic [15:0] LAST_ACTIVE  = 16'(V_ACTIVE - 1);
  localparam logic [15:0] LAST_VFRONT  = 16'(V_FRONT - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [9:0]  lp_q, lp_d;
  logic [7:0]  camera_data_q, camera_data_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic        frame_done_q, frame_done_d;

  logic        line_end;
  logic [15:0] last_line;
  logic [10:0] pix;
  logic [10:0] stripe_lo;
  logic [10:0] stripe_hi;
  logic        in_stripe;
  logic [7:0]  bg_y;

  assign line_end  = (byte_cnt_q == LAST_BYTE);
  assign pix       = byte_cnt_q[11:1];
  assign stripe_lo = {1'b0, lp_q};
  assign stripe_hi = stripe_lo + 11'(LINE_WIDTH);
  assign in_stripe = (pix >= stripe_lo) && (pix < stripe_hi);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    line_cnt_d = line_cnt_q;
    lp_d       = lp_q;
    last_line  = LAST_VFRONT;
    case (state_q)
      ST_VSYNC:  last_line = LAST_VSYNC;
      ST_VBACK:  last_line = LAST_VBACK;
      ST_ACTIVE: last_line = LAST_ACTIVE;
      default:   last_line = LAST_VFRONT;
    endcase

    if (state_q == ST_IDLE) begin
      byte_cnt_d = '0;
      line_cnt_d = '0;
      if (enable) begin
        state_d = ST_VSYNC;
        lp_d    = line_pos;
      end
    end else begin
      byte_cnt_d = line_end ? 16'd0 : byte_cnt_q + 16'd1;
      if (line_end) begin
        if (line_cnt_q == last_line) begin
          line_cnt_d = '0;
          case (state_q)
            ST_VSYNC:  state_d = ST_VBACK;
            ST_VBACK:  state_d = ST_ACTIVE;
            ST_ACTIVE: state_d = ST_VFRONT;
            default: begin
              // enable is only looked at here, so a frame in flight always completes
              if (enable) begin
                state_d = ST_VSYNC;
                lp_d    = line_pos;
              end else begin
                state_d = ST_IDLE;
              end
            end
          endcase
        end else begin
          line_cnt_d = line_cnt_q + 16'd1;
        end
      end
    end
  end

  // Outputs are decoded from the current state/counters and registered together
  always_comb begin
    vsync_d       = (state_q == ST_VSYNC);
    href_d        = (state_q == ST_ACTIVE) && (byte_cnt_q < ACTIVE_BYTES);
    frame_done_d  = (state_q == ST_VFRONT) && line_end && (line_cnt_q == LAST_VFRONT);
    camera_data_d = 8'd0;
    if (href_d) begin
      if (byte_cnt_q[0]) begin
        camera_data_d = CHROMA_MID;
      end else begin
        camera_data_d = in_stripe ? 8'(LINE_Y) : bg_y;
      end
    end
  end

`ifdef CAMERA_EMU_LFSR_NOISE_EN
  logic [15:0] lfsr_state;
  logic        lfsr_step;
  logic        lfsr_reseed;

  assign lfsr_reseed = (state_d == ST_VSYNC) && (state_q != ST_VSYNC);
  assign lfsr_step   = href_d && !byte_cnt_q[0];
  assign bg_y        = 8'(BG_Y) - {4'd0, lfsr_state[3:0]};

  camera_emu_lfsr u_lfsr (
    .clk      (pixel_clock),
    .rst      (reset),
    .step     (lfsr_step),
    .reseed   (lfsr_reseed),
    .lfsr_out (lfsr_state)
  );
`else
  assign bg_y = 8'(BG_Y);
`endif

  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      line_cnt_q    <= '0;
      lp_q          <= '0;
      camera_data_q <= '0;
      href_q        <= 1'b0;
      vsync_q       <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      line_cnt_q    <= line_cnt_d;
      lp_q          <= lp_d;
      camera_data_q <= camera_data_d;
      href_q        <= href_d;
      vsync_q       <= vsync_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign camera_data = camera_data_q;
  assign href        = href_q;
  assign vsync       = vsync_q;
  assign frame_done  = frame_done_q;

endmodule
